alu_exec_unit: RTL and testbench

- Integer execute stage directly downstream of the reservation station.
- Takes the oldest-ready instruction the station presents and returns execute_clear/execute_slot so the station frees that slot.
- Computes the result in a 2-stage pipeline, queues it in a result FIFO, and broadcasts it on the CDB through a req/grant handshake with the CDB arbiter.

---
 rtl/alu_exec_unit.sv | 182 ++++++++++++++++++
 tb/tb_alu_exec_unit.sv | 440 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - integer execute stage: 2-stage ALU, result FIFO, CDB req/grant
//
// Purpose:
//   Accepts the oldest-ready instruction from the reservation station, computes
//   its result over two pipeline stages, queues it in a small result FIFO and
//   broadcasts the FIFO head on the CDB using a req/grant handshake.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   flush                 squash all in-flight and queued work
//   rs_ready/_slot        station offers an instruction in the given slot
//   rs_op, rs_opcode      ALU function and RISC-V major opcode
//   rs_vj, rs_vk, rs_imm  operand A, register operand B, sign-extended immediate
//   rs_rob_tag            destination ROB tag
//   execute_clear/_slot   instruction taken this cycle and its slot
//   cdb_req/grant         FIFO head valid / arbiter grant
//   cdb_tag, cdb_value    FIFO head tag and result (zero when FIFO is empty)
//   busy                  any pipeline stage or FIFO entry valid

module alu_exec_unit #(
  parameter int XLEN       = 32,
  parameter int TAG_W      = 5,
  parameter int SLOT_W     = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              rs_ready,
  input  logic [SLOT_W-1:0] rs_ready_slot,
  input  logic [3:0]        rs_op,
  input  logic [6:0]        rs_opcode,
  input  logic [XLEN-1:0]   rs_vj,
  input  logic [XLEN-1:0]   rs_vk,
  input  logic [XLEN-1:0]   rs_imm,
  input  logic [TAG_W-1:0]  rs_rob_tag,
  output logic              execute_clear,
  output logic [SLOT_W-1:0] execute_slot,
  output logic              cdb_req,
  input  logic              cdb_grant,
  output logic [TAG_W-1:0]  cdb_tag,
  output logic [XLEN-1:0]   cdb_value,
  output logic              busy
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_C = FIFO_DEPTH[CNT_W:0];

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  // Stage 1 registers
  logic              v1;
  logic [3:0]        s1_op;
  logic [6:0]        s1_opcode;
  logic [XLEN-1:0]   s1_a;
  logic [XLEN-1:0]   s1_b;
  logic [XLEN-1:0]   s1_imm;
  logic [TAG_W-1:0]  s1_tag;

  // Stage 2 registers
  logic              v2;
  logic [XLEN-1:0]   s2_result;
  logic [TAG_W-1:0]  s2_tag;

  // Result FIFO
  logic [XLEN-1:0]   fifo_value [FIFO_DEPTH];
  logic [TAG_W-1:0]  fifo_tag   [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;

  logic [CNT_W:0]    occupancy;
  logic              push;
  logic              pop;
  logic [XLEN-1:0]   alu_result;
  logic [4:0]        shamt;

  // Every instruction already in flight owns a future FIFO entry, so counting
  // v1/v2 against the free space guarantees stage 2 can always push. A pop in
  // the same cycle is deliberately not credited, keeping this path short.
  assign occupancy = {1'b0, count} + {{CNT_W{1'b0}}, v1} + {{CNT_W{1'b0}}, v2};

  assign execute_clear = rst_n & rs_ready & ~flush & (occupancy < DEPTH_C);
  assign execute_slot  = execute_clear ? rs_ready_slot : '0;

  assign cdb_req   = (count != '0);
  assign cdb_tag   = cdb_req ? fifo_tag[rd_ptr]   : '0;
  assign cdb_value = cdb_req ? fifo_value[rd_ptr] : '0;
  assign busy      = v1 | v2 | cdb_req;

  assign push = v2 & ~flush;
  assign pop  = cdb_req & cdb_grant & ~flush;

  // Valid bits for both stages
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
    end else if (flush) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
    end else begin
      v1 <= execute_clear;
      v2 <= v1;
    end
  end

  // Stage 1 payload; operand B is muxed here so stage 2 sees a single operand
  always_ff @(posedge clk) begin
    if (execute_clear) begin
      s1_op     <= rs_op;
      s1_opcode <= rs_opcode;
      s1_a      <= rs_vj;
      s1_b      <= (rs_opcode == OPC_OP_IMM) ? rs_imm : rs_vk;
      s1_imm    <= rs_imm;
      s1_tag    <= rs_rob_tag;
    end
  end

  always_comb begin
    alu_result = '0;
    shamt      = s1_b[4:0];
    case (s1_opcode)
      OPC_OP, OPC_OP_IMM: begin
        case (s1_op)
          4'd0: alu_result = s1_a + s1_b;
          // There is no SUBI; an OP-IMM with op=1 degrades to ADD
          4'd1: alu_result = (s1_opcode == OPC_OP_IMM) ? (s1_a + s1_b) : (s1_a - s1_b);
          4'd2: alu_result = s1_a << shamt;
          4'd3: alu_result = {{(XLEN-1){1'b0}}, ($signed(s1_a) < $signed(s1_b))};
          4'd4: alu_result = {{(XLEN-1){1'b0}}, (s1_a < s1_b)};
          4'd5: alu_result = s1_a ^ s1_b;
          4'd6: alu_result = s1_a >> shamt;
          4'd7: alu_result = $unsigned($signed(s1_a) >>> shamt);
          4'd8: alu_result = s1_a | s1_b;
          4'd9: alu_result = s1_a & s1_b;
          default: alu_result = '0;
        endcase
      end
      OPC_LUI: alu_result = s1_imm;
      // Unknown opcodes still complete with a zero result so the ROB entry retires
      default: alu_result = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    s2_result <= alu_result;
    s2_tag    <= s1_tag;
  end

  // FIFO storage; pointers are reset, contents are not
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_value[wr_ptr] <= s2_result;
      fifo_tag[wr_ptr]   <= s2_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - scoreboard testbench for alu_exec_unit
module tb_alu_exec_unit;

  localparam int XLEN       = 32;
  localparam int TAG_W      = 5;
  localparam int SLOT_W     = 3;
  localparam int FIFO_DEPTH = 4;

  localparam logic [6:0] OP  = 7'b0110011;
  localparam logic [6:0] OPI = 7'b0010011;
  localparam logic [6:0] LUI = 7'b0110111;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              flush = 1'b0;
  logic              rs_ready = 1'b0;
  logic [SLOT_W-1:0] rs_ready_slot = '0;
  logic [3:0]        rs_op = '0;
  logic [6:0]        rs_opcode = '0;
  logic [XLEN-1:0]   rs_vj = '0;
  logic [XLEN-1:0]   rs_vk = '0;
  logic [XLEN-1:0]   rs_imm = '0;
  logic [TAG_W-1:0]  rs_rob_tag = '0;
  logic              execute_clear;
  logic [SLOT_W-1:0] execute_slot;
  logic              cdb_req;
  logic              cdb_grant = 1'b0;
  logic [TAG_W-1:0]  cdb_tag;
  logic [XLEN-1:0]   cdb_value;
  logic              busy;

  int tests = 0;
  int fails = 0;

  logic [TAG_W-1:0] exp_tag_q [$];
  logic [XLEN-1:0]  exp_val_q [$];
  logic [TAG_W-1:0] et;
  logic [XLEN-1:0]  ev;

  // Directed operation table with hand-computed results
  logic [3:0]      t_op  [5] = '{4'd7, 4'd3, 4'd4, 4'd1, 4'd0};
  logic [6:0]      t_opc [5] = '{OPI, OP, OP, OP, LUI};
  logic [XLEN-1:0] t_vj  [5] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd3, 32'd0};
  logic [XLEN-1:0] t_vk  [5] = '{32'd0, 32'd1, 32'd1, 32'd5, 32'd0};
  logic [XLEN-1:0] t_imm [5] = '{32'd4, 32'd0, 32'd0, 32'd0, 32'h1234_5000};
  logic [XLEN-1:0] t_exp [5] = '{32'hF800_0000, 32'd1, 32'd0, 32'hFFFF_FFFE, 32'h1234_5000};

  alu_exec_unit #(
    .XLEN(XLEN), .TAG_W(TAG_W), .SLOT_W(SLOT_W), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .rs_ready(rs_ready), .rs_ready_slot(rs_ready_slot), .rs_op(rs_op),
    .rs_opcode(rs_opcode), .rs_vj(rs_vj), .rs_vk(rs_vk), .rs_imm(rs_imm),
    .rs_rob_tag(rs_rob_tag), .execute_clear(execute_clear), .execute_slot(execute_slot),
    .cdb_req(cdb_req), .cdb_grant(cdb_grant), .cdb_tag(cdb_tag),
    .cdb_value(cdb_value), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  // Reference ALU written from the instruction semantics
  function automatic logic [XLEN-1:0] model_alu(input logic [3:0] op, input logic [6:0] opc,
                                                input logic [XLEN-1:0] a, input logic [XLEN-1:0] vk,
                                                input logic [XLEN-1:0] imm);
    logic [XLEN-1:0] b;
    b = (opc == OPI) ? imm : vk;
    if (opc == LUI) return imm;
    if (opc != OP && opc != OPI) return '0;
    case (op)
      4'd0: return a + b;
      4'd1: return (opc == OPI) ? a + b : a + ~b + XLEN'(1);
      4'd2: return a << b[4:0];
      4'd3: return ($signed(a) < $signed(b)) ? XLEN'(1) : '0;
      4'd4: return (a < b) ? XLEN'(1) : '0;
      4'd5: return a ^ b;
      4'd6: return a >> b[4:0];
      4'd7: return $unsigned($signed(a) >>> b[4:0]);
      4'd8: return a | b;
      4'd9: return a & b;
      default: return '0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [SLOT_W-1:0] slot, input logic [3:0] op, input logic [6:0] opc,
                       input logic [XLEN-1:0] vj, input logic [XLEN-1:0] vk,
                       input logic [XLEN-1:0] imm, input logic [TAG_W-1:0] tag);
    rs_ready      = 1'b1;
    rs_ready_slot = slot;
    rs_op         = op;
    rs_opcode     = opc;
    rs_vj         = vj;
    rs_vk         = vk;
    rs_imm        = imm;
    rs_rob_tag    = tag;
  endtask

  task automatic idle();
    rs_ready = 1'b0;
  endtask

  // Called at the sampling point: an accepted instruction enters the scoreboard
  task automatic record_accept();
    if (execute_clear) begin
      exp_tag_q.push_back(rs_rob_tag);
      exp_val_q.push_back(model_alu(rs_op, rs_opcode, rs_vj, rs_vk, rs_imm));
    end
  endtask

  task automatic sb_clear();
    exp_tag_q.delete();
    exp_val_q.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cdb_grant = 1'b1;
    drive(3'd5, 4'd0, OP, 32'd1, 32'd2, 32'd0, 5'd1);
    tick();
    tick();
    @(negedge clk);
    tests++; if (execute_clear !== 1'b0) begin fails++; $display("FAIL reset_execute_clear: got %b expected 0", execute_clear); end
    tests++; if (execute_slot !== '0) begin fails++; $display("FAIL reset_execute_slot: got %0d expected 0", execute_slot); end
    tests++; if (cdb_req !== 1'b0) begin fails++; $display("FAIL reset_cdb_req: got %b expected 0", cdb_req); end
    tests++; if (cdb_tag !== '0) begin fails++; $display("FAIL reset_cdb_tag: got %0d expected 0", cdb_tag); end
    tests++; if (cdb_value !== '0) begin fails++; $display("FAIL reset_cdb_value: got %h expected 0", cdb_value); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
    tick();
    rst_n = 1'b1;
    cdb_grant = 1'b0;
    idle();
    tick();
  endtask

  task automatic test_single_add();
    drive(3'd6, 4'd0, OP, 32'd5, 32'd7, 32'd0, 5'd3);
    @(negedge clk);
    tests++; if (execute_clear !== 1'b1) begin fails++; $display("FAIL add_execute_clear: got %b expected 1", execute_clear); end
    tests++; if (execute_slot !== 3'd6) begin fails++; $display("FAIL add_execute_slot: got %0d expected 6", execute_slot); end
    record_accept();
    tick();
    idle();
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      tests++; if (cdb_req !== 1'b0) begin fails++; $display("FAIL add_early_req_T%0d: got %b expected 0", k, cdb_req); end
      tick();
    end
    @(negedge clk);
    tests++; if (cdb_req !== 1'b1) begin fails++; $display("FAIL add_req_T3: got %b expected 1", cdb_req); end
    tests++; if (cdb_tag !== 5'd3 || cdb_value !== 32'd12) begin
      fails++; $display("FAIL add_result: got tag %0d value %h expected tag 3 value 0000000c", cdb_tag, cdb_value);
    end
    if (exp_tag_q.size() != 0) begin
      et = exp_tag_q.pop_front(); ev = exp_val_q.pop_front();
      tests++; if (cdb_tag !== et || cdb_value !== ev) begin
        fails++; $display("FAIL add_scoreboard: got tag %0d value %h expected tag %0d value %h", cdb_tag, cdb_value, et, ev);
      end
    end
    cdb_grant = 1'b1;
    tick();
    cdb_grant = 1'b0;
    @(negedge clk);
    tests++; if (cdb_req !== 1'b0) begin fails++; $display("FAIL add_req_after_grant: got %b expected 0", cdb_req); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL add_busy_after_grant: got %b expected 0", busy); end
    tick();
  endtask

  task automatic test_ops();
    int w;
    for (int i = 0; i < 5; i++) begin
      drive(SLOT_W'(i), t_op[i], t_opc[i], t_vj[i], t_vk[i], t_imm[i], TAG_W'(10 + i));
      @(negedge clk);
      tests++; if (execute_clear !== 1'b1) begin fails++; $display("FAIL ops%0d_accept: got %b expected 1", i, execute_clear); end
      record_accept();
      tick();
      idle();
      w = 0;
      while (w < 8) begin
        @(negedge clk);
        if (cdb_req) break;
        tick();
        w++;
      end
      tests++; if (cdb_req !== 1'b1 || w != 2) begin
        fails++; $display("FAIL ops%0d_latency: req %b after %0d idle cycles, expected req 1 after 2", i, cdb_req, w);
      end
      tests++; if (cdb_tag !== TAG_W'(10 + i) || cdb_value !== t_exp[i]) begin
        fails++; $display("FAIL ops%0d_result: got tag %0d value %h expected tag %0d value %h", i, cdb_tag, cdb_value, 10 + i, t_exp[i]);
      end
      if (exp_tag_q.size() == 0) begin
        tests++; fails++; $display("FAIL ops%0d_scoreboard: scoreboard empty, got tag %0d", i, cdb_tag);
      end else begin
        et = exp_tag_q.pop_front(); ev = exp_val_q.pop_front();
        tests++; if (cdb_tag !== et || cdb_value !== ev) begin
          fails++; $display("FAIL ops%0d_scoreboard: got tag %0d value %h expected tag %0d value %h", i, cdb_tag, cdb_value, et, ev);
        end
      end
      cdb_grant = 1'b1;
      tick();
      cdb_grant = 1'b0;
    end
  endtask

  task automatic test_backpressure();
    int next_tag = 1;
    int accepts = 0;
    int drained;
    cdb_grant = 1'b0;
    for (int c = 0; c < 12; c++) begin
      drive(SLOT_W'(c), 4'd0, OP, XLEN'(next_tag * 10), 32'd1, 32'd0, TAG_W'(next_tag));
      @(negedge clk);
      if (execute_clear) begin
        record_accept();
        accepts++;
        next_tag++;
      end
      if (c >= 4) begin
        tests++; if (cdb_req !== 1'b1 || cdb_tag !== 5'd1 || cdb_value !== 32'd11) begin
          fails++; $display("FAIL bp_head_stable_c%0d: got req %b tag %0d value %h expected req 1 tag 1 value 0000000b", c, cdb_req, cdb_tag, cdb_value);
        end
      end
      tick();
    end
    @(negedge clk);
    tests++; if (accepts != FIFO_DEPTH) begin fails++; $display("FAIL bp_accept_count: got %0d expected %0d", accepts, FIFO_DEPTH); end
    tests++; if (execute_clear !== 1'b0) begin fails++; $display("FAIL bp_full_no_accept: got %b expected 0", execute_clear); end
    if (exp_tag_q.size() != 0) begin
      et = exp_tag_q.pop_front(); ev = exp_val_q.pop_front();
      tests++; if (cdb_tag !== et || cdb_value !== ev) begin
        fails++; $display("FAIL bp_first_pop: got tag %0d value %h expected tag %0d value %h", cdb_tag, cdb_value, et, ev);
      end
    end
    cdb_grant = 1'b1;
    tick();
    cdb_grant = 1'b0;
    @(negedge clk);
    tests++; if (execute_clear !== 1'b1 || rs_rob_tag !== 5'd5) begin
      fails++; $display("FAIL bp_accept_after_pop: got clear %b for tag %0d expected clear 1 for tag 5", execute_clear, rs_rob_tag);
    end
    record_accept();
    tick();
    idle();
    cdb_grant = 1'b1;
    drained = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (cdb_req) begin
        if (exp_tag_q.size() == 0) begin
          tests++; fails++; $display("FAIL bp_drain_extra: unexpected tag %0d", cdb_tag);
        end else begin
          et = exp_tag_q.pop_front(); ev = exp_val_q.pop_front();
          drained++;
          tests++; if (cdb_tag !== et || cdb_value !== ev) begin
            fails++; $display("FAIL bp_drain_order: got tag %0d value %h expected tag %0d value %h", cdb_tag, cdb_value, et, ev);
          end
        end
      end
      if (exp_tag_q.size() == 0) break;
      tick();
    end
    tick();
    cdb_grant = 1'b0;
    tests++; if (drained != 4) begin fails++; $display("FAIL bp_drain_count: got %0d expected 4", drained); end
  endtask

  task automatic test_streaming();
    int issued = 0;
    int pops = 0;
    int first_pop = -1;
    int last_pop = 0;
    int last_accept = 0;
    cdb_grant = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (issued < 10) drive(SLOT_W'(issued), 4'd0, OP, XLEN'(issued + 1), 32'h100, 32'd0, TAG_W'(issued + 1));
      else idle();
      @(negedge clk);
      if (execute_clear) begin
        record_accept();
        issued++;
        last_accept = cyc;
      end
      if (cdb_req && cdb_grant) begin
        if (exp_tag_q.size() == 0) begin
          tests++; fails++; $display("FAIL stream_extra: unexpected tag %0d", cdb_tag);
        end else begin
          et = exp_tag_q.pop_front(); ev = exp_val_q.pop_front();
          tests++; if (cdb_tag !== et || cdb_value !== ev) begin
            fails++; $display("FAIL stream_order: got tag %0d value %h expected tag %0d value %h", cdb_tag, cdb_value, et, ev);
          end
        end
        pops++;
        if (first_pop < 0) first_pop = cyc;
        last_pop = cyc;
      end
      if (pops == 10) break;
      tick();
    end
    tick();
    cdb_grant = 1'b0;
    idle();
    @(negedge clk);
    tests++; if (issued != 10 || last_accept != 9) begin
      fails++; $display("FAIL stream_accepts: got %0d accepts ending cycle %0d expected 10 ending cycle 9", issued, last_accept);
    end
    tests++; if (pops != 10 || (last_pop - first_pop) != 9) begin
      fails++; $display("FAIL stream_throughput: got %0d pops over span %0d expected 10 over span 9", pops, last_pop - first_pop);
    end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL stream_busy_end: got %b expected 0", busy); end
    tick();
  endtask

  task automatic test_flush();
    cdb_grant = 1'b0;
    for (int c = 0; c < 4; c++) begin
      drive(SLOT_W'(c), 4'd0, OP, XLEN'(c), 32'd1, 32'd0, TAG_W'(20 + c));
      @(negedge clk);
      tests++; if (execute_clear !== 1'b1) begin fails++; $display("FAIL flush_fill_accept%0d: got %b expected 1", c, execute_clear); end
      record_accept();
      tick();
    end
    drive(3'd0, 4'd0, OP, 32'd9, 32'd9, 32'd0, 5'd28);
    flush = 1'b1;
    cdb_grant = 1'b1;
    @(negedge clk);
    tests++; if (execute_clear !== 1'b0) begin fails++; $display("FAIL flush_cycle_accept: got %b expected 0", execute_clear); end
    tests++; if (busy !== 1'b1 || cdb_req !== 1'b1) begin
      fails++; $display("FAIL flush_cycle_state: got busy %b req %b expected busy 1 req 1", busy, cdb_req);
    end
    tick();
    flush = 1'b0;
    cdb_grant = 1'b0;
    sb_clear();
    drive(3'd1, 4'd5, OP, 32'h0000_F0F0, 32'h0000_0FF0, 32'd0, 5'd29);
    @(negedge clk);
    tests++; if (cdb_req !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL flush_after_idle: got req %b busy %b expected 0 0", cdb_req, busy);
    end
    tests++; if (execute_clear !== 1'b1) begin fails++; $display("FAIL flush_after_accept: got %b expected 1", execute_clear); end
    record_accept();
    tick();
    idle();
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      tests++; if (cdb_req !== 1'b0) begin fails++; $display("FAIL flush_early_req_T%0d: got %b expected 0", k, cdb_req); end
      tick();
    end
    @(negedge clk);
    tests++; if (cdb_req !== 1'b1 || cdb_tag !== 5'd29 || cdb_value !== 32'h0000_FF00) begin
      fails++; $display("FAIL flush_new_result: got req %b tag %0d value %h expected req 1 tag 29 value 0000ff00", cdb_req, cdb_tag, cdb_value);
    end
    if (exp_tag_q.size() != 0) begin
      et = exp_tag_q.pop_front(); ev = exp_val_q.pop_front();
      tests++; if (cdb_tag !== et || cdb_value !== ev) begin
        fails++; $display("FAIL flush_scoreboard: got tag %0d value %h expected tag %0d value %h", cdb_tag, cdb_value, et, ev);
      end
    end
    cdb_grant = 1'b1;
    tick();
    cdb_grant = 1'b0;
  endtask

  task automatic test_reset_mid();
    cdb_grant = 1'b0;
    for (int c = 0; c < 4; c++) begin
      drive(SLOT_W'(c), 4'd9, OP, 32'hFFFF_0000, XLEN'(c), 32'd0, TAG_W'(c + 1));
      @(negedge clk);
      record_accept();
      tick();
    end
    idle();
    for (int c = 0; c < 4; c++) tick();
    rst_n = 1'b0;
    cdb_grant = 1'b1;
    drive(3'd2, 4'd0, OP, 32'd1, 32'd1, 32'd0, 5'd7);
    @(negedge clk);
    tests++; if (execute_clear !== 1'b0) begin fails++; $display("FAIL rstmid_accept_in_reset: got %b expected 0", execute_clear); end
    tick();
    rst_n = 1'b1;
    cdb_grant = 1'b0;
    idle();
    sb_clear();
    @(negedge clk);
    tests++; if (cdb_req !== 1'b0 || cdb_tag !== '0 || cdb_value !== '0) begin
      fails++; $display("FAIL rstmid_cdb: got req %b tag %0d value %h expected all 0", cdb_req, cdb_tag, cdb_value);
    end
    tests++; if (busy !== 1'b0 || execute_clear !== 1'b0 || execute_slot !== '0) begin
      fails++; $display("FAIL rstmid_status: got busy %b clear %b slot %0d expected all 0", busy, execute_clear, execute_slot);
    end
    tick();
    drive(3'd4, 4'd8, OP, 32'h0000_A000, 32'h0000_000B, 32'd0, 5'd17);
    @(negedge clk);
    tests++; if (execute_clear !== 1'b1 || execute_slot !== 3'd4) begin
      fails++; $display("FAIL rstmid_cold_accept: got clear %b slot %0d expected 1 4", execute_clear, execute_slot);
    end
    record_accept();
    tick();
    idle();
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      tests++; if (cdb_req !== 1'b0) begin fails++; $display("FAIL rstmid_early_req_T%0d: got %b expected 0", k, cdb_req); end
      tick();
    end
    @(negedge clk);
    tests++; if (cdb_req !== 1'b1 || cdb_tag !== 5'd17 || cdb_value !== 32'h0000_A00B) begin
      fails++; $display("FAIL rstmid_cold_result: got req %b tag %0d value %h expected req 1 tag 17 value 0000a00b", cdb_req, cdb_tag, cdb_value);
    end
    if (exp_tag_q.size() != 0) begin
      et = exp_tag_q.pop_front(); ev = exp_val_q.pop_front();
      tests++; if (cdb_tag !== et || cdb_value !== ev) begin
        fails++; $display("FAIL rstmid_scoreboard: got tag %0d value %h expected tag %0d value %h", cdb_tag, cdb_value, et, ev);
      end
    end
    cdb_grant = 1'b1;
    tick();
    cdb_grant = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_ops();
    test_backpressure();
    test_streaming();
    test_flush();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
